// File: rtl/unshifter_pkg.sv
// rtl/unshifter_pkg.sv - shared opcodes, FSM state type and width default for unshifter_seq
package unshifter_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int AMT_W         = 3;

    // Forward operation that produced the data; the unshifter applies the inverse.
    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SHL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SHR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/unshift_step.sv
// rtl/unshift_step.sv - combinational single-bit inverse of a forward rotate/shift
module unshift_step
    import unshifter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       opcode_i,
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (opcode_i)
            OP_ROL:  data_o = {data_i[0], data_i[WIDTH-1:1]};
            OP_SHL:  data_o = {1'b0, data_i[WIDTH-1:1]};
            OP_ROR:  data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
            OP_SHR:  data_o = {data_i[WIDTH-2:0], 1'b0};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/unshifter_seq.sv
// rtl/unshifter_seq.sv - sequential one-bit-per-cycle inverse shifter; optional lossy flag under UNSHIFTER_LOSS_FLAG_EN
module unshifter_seq
    import unshifter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amount,
    input  logic [1:0]       opcode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out
`ifdef UNSHIFTER_LOSS_FLAG_EN
    ,
    output logic             lossy
`endif
);

    state_t           state_q, state_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] step_out;

    unshift_step #(.WIDTH(WIDTH)) u_step (
        .data_i   (work_q),
        .opcode_i (op_q),
        .data_o   (step_out)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        work_d   = work_q;
        op_d     = op_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    work_d  = data_in;
                    op_d    = opcode;
                    count_d = amount;
                    if (amount != '0) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = data_in;
                    end
                end
            end
            ST_SHIFT: begin
                work_d  = step_out;
                count_d = count_q - 3'd1;
                if (count_q == 3'd1) begin
                    state_d  = ST_DONE;
                    result_d = step_out;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output flags are computed from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            work_q   <= '0;
            op_q     <= OP_ROL;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            work_q   <= work_d;
            op_q     <= op_d;
            result_q <= result_d;
            busy_q   <= (state_d == ST_SHIFT);
            done_q   <= (state_d == ST_DONE);
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = result_q;

`ifdef UNSHIFTER_LOSS_FLAG_EN
    logic lossy_q;

    // Only a completion out of SHIFT implies amount != 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            lossy_q <= 1'b0;
        end else begin
            lossy_q <= (state_d == ST_DONE) && (state_q == ST_SHIFT)
                       && ((op_q == OP_SHL) || (op_q == OP_SHR));
        end
    end

    assign lossy = lossy_q;
`endif

endmodule

// File: tb/tb_unshifter_seq.sv
// tb/tb_unshifter_seq.sv - randomized self-checking bench for unshifter_seq against an arithmetic reference
module tb_unshifter_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] data_in;
    logic [2:0] amount;
    logic [1:0] opcode;
    logic       busy;
    logic       done;
    logic [7:0] data_out;
`ifdef UNSHIFTER_LOSS_FLAG_EN
    logic       lossy;
`endif

    int n_cmp = 0;
    int n_mis = 0;
    logic [7:0] last_result = 8'h00;

    unshifter_seq #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .data_in  (data_in),
        .amount   (amount),
        .opcode   (opcode),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
`ifdef UNSHIFTER_LOSS_FLAG_EN
        ,
        .lossy    (lossy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Whole-distance inverse of the forward operation, done in one arithmetic step.
    function automatic logic [7:0] ref_unshift(input logic [7:0] d, input int a, input logic [1:0] op);
        logic [15:0] w;
        case (op)
            2'b00: begin w = {d, d} >> a;       return w[7:0];  end
            2'b01: begin w = {8'h00, d} >> a;   return w[7:0];  end
            2'b10: begin w = {d, d} << a;       return w[15:8]; end
            default: begin w = {8'h00, d} << a; return w[7:0];  end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs(input bit allow_start);
        start   = allow_start ? 1'($urandom_range(0, 1)) : 1'b0;
        data_in = 8'($urandom);
        amount  = 3'($urandom);
        opcode  = 2'($urandom);
    endtask

    // Called at a point where the DUT accepts; returns positioned in the done cycle.
    task automatic run_req(input logic [7:0] d, input logic [2:0] a, input logic [1:0] op, input bit disturb);
        logic [7:0] exp;
        exp     = ref_unshift(d, int'(a), op);
        data_in = d;
        amount  = a;
        opcode  = op;
        start   = 1'b1;
        tick();
        for (int k = 1; k <= int'(a); k++) begin
            check_eq("busy_in_shift", 32'(busy), 32'd1);
            check_eq("no_done_in_shift", 32'(done), 32'd0);
            check_eq("data_out_held_in_shift", 32'(data_out), 32'(last_result));
            scramble_inputs(disturb);
            tick();
        end
        start = 1'b0;
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("busy_low_at_done", 32'(busy), 32'd0);
        check_eq("result", 32'(data_out), 32'(exp));
`ifdef UNSHIFTER_LOSS_FLAG_EN
        check_eq("lossy", 32'(lossy), 32'(op[0] && (a != 3'd0)));
`endif
        last_result = exp;
    endtask

    task automatic idle_tail(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            scramble_inputs(1'b0);
            tick();
            check_eq("done_single_cycle", 32'(done), 32'd0);
            check_eq("busy_idle", 32'(busy), 32'd0);
            check_eq("data_out_hold", 32'(data_out), 32'(last_result));
`ifdef UNSHIFTER_LOSS_FLAG_EN
            check_eq("lossy_idle", 32'(lossy), 32'd0);
`endif
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b1;
        data_in = 8'hA5;
        amount  = 3'd2;
        opcode  = 2'b01;
        tick();
        tick();
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_data_out", 32'(data_out), 32'h00);
`ifdef UNSHIFTER_LOSS_FLAG_EN
        check_eq("reset_lossy", 32'(lossy), 32'd0);
`endif
        reset = 1'b0;
        start = 1'b0;
        tick();
        check_eq("post_reset_idle", 32'(busy), 32'd0);

        // Directed vectors with fixed expectations.
        run_req(8'h4B, 3'd3, 2'b00, 1'b0);
        check_eq("vec_rol", 32'(data_out), 32'h69);
        idle_tail(1);
        run_req(8'hF0, 3'd4, 2'b01, 1'b0);
        check_eq("vec_shl", 32'(data_out), 32'h0F);
        idle_tail(1);
        run_req(8'h81, 3'd1, 2'b10, 1'b0);
        check_eq("vec_ror", 32'(data_out), 32'h03);
        idle_tail(1);
        run_req(8'h5A, 3'd0, 2'b11, 1'b0);
        check_eq("vec_shr_zero", 32'(data_out), 32'h5A);
        idle_tail(2);

        // Start during SHIFT is ignored; start held in DONE chains a new request.
        run_req(8'hC3, 3'd6, 2'b00, 1'b1);
        run_req(8'h3C, 3'd2, 2'b11, 1'b0);
        run_req(8'h77, 3'd0, 2'b01, 1'b0);
        run_req(8'h18, 3'd7, 2'b10, 1'b1);
        idle_tail(2);

        // Reset in the second SHIFT cycle aborts with no completion.
        data_in = 8'hE7;
        amount  = 3'd5;
        opcode  = 2'b10;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_eq("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_data_out", 32'(data_out), 32'h00);
        last_result = 8'h00;
        idle_tail(8);

        // Randomized requests, mixing chained, disturbed and idle-gapped cases.
        for (int i = 0; i < 60; i++) begin
            run_req(8'($urandom), 3'($urandom), 2'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                idle_tail(int'($urandom_range(1, 3)));
            end
        end
        idle_tail(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
